// File: rtl/prog_mode_ctrl_if.sv
// Memory-port bundle shared by the CPU, the UART programmer and the two
// memory macros. The mode controller sits on the slave side. It takes the
// CPU and UART requests and drives the memory ports.
//
// Transfer semantics: there is no valid/ready pair. A write enable is a
// single-cycle strobe qualified by the address and data sampled in the same
// cycle. The memories always accept, so there is no backpressure and a
// strobe is never held.
interface prog_mode_ctrl_if #(
    parameter int ADDR_W = 14
);
    // UART programmer side
    logic              upg_done_o;
    logic              upg_wen_o;
    logic [14:0]       upg_adr_o;
    logic [31:0]       upg_dat_o;

    // CPU side
    logic [ADDR_W-1:0] cpu_imem_addr;
    logic [ADDR_W-1:0] cpu_dmem_addr;
    logic              cpu_dmem_wen;
    logic [31:0]       cpu_dmem_wdata;

    // Memory macro side
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_wen;
    logic [31:0]       imem_wdata;
    logic [ADDR_W-1:0] dmem_addr;
    logic              dmem_wen;
    logic [31:0]       dmem_wdata;

    // Requesters and memories: drives the requests, observes the memory ports
    modport master (
        output upg_done_o, upg_wen_o, upg_adr_o, upg_dat_o,
        output cpu_imem_addr, cpu_dmem_addr, cpu_dmem_wen, cpu_dmem_wdata,
        input  imem_addr, imem_wen, imem_wdata,
        input  dmem_addr, dmem_wen, dmem_wdata
    );

    // Mode controller: observes the requests, drives the memory ports
    modport slave (
        input  upg_done_o, upg_wen_o, upg_adr_o, upg_dat_o,
        input  cpu_imem_addr, cpu_dmem_addr, cpu_dmem_wen, cpu_dmem_wdata,
        output imem_addr, imem_wen, imem_wdata,
        output dmem_addr, dmem_wen, dmem_wdata
    );
endinterface

// File: rtl/prog_mode_ctrl.sv
// Mode sequencer and memory-port arbiter. It debounces start_pg and moves
// the system between RUN (the CPU owns the memories), PROG (the UART
// programmer owns them and the CPU is held in reset) and RELEASE (a short
// reset tail before the CPU restarts).
module prog_mode_ctrl #(
    parameter int DEB_CYCLES     = 16,
    parameter int RELEASE_CYCLES = 4,
    parameter int ADDR_W         = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_pg,
    prog_mode_ctrl_if.slave      bus,
    output logic                 cpu_rst,
    output logic                 upg_rst,
    output logic                 prog_mode,
    output logic [15:0]          load_count,
    output logic [1:0]           state_o
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PROG    = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int REL_W = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYCLES - 1);
    localparam logic [REL_W-1:0] REL_MAX = REL_W'(RELEASE_CYCLES - 1);

    state_e            state_q, state_d;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic [REL_W-1:0]  rel_cnt_q, rel_cnt_d;
    logic              armed_q, armed_d;
    logic [15:0]       load_count_q, load_count_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              upg_rst_q, upg_rst_d;
    logic              prog_mode_q, prog_mode_d;

    // State and counter registers; reset lands in RELEASE so the CPU gets
    // its full reset tail after power-up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_RELEASE;
            deb_cnt_q    <= '0;
            rel_cnt_q    <= '0;
            armed_q      <= 1'b1;
            load_count_q <= '0;
            cpu_rst_q    <= 1'b1;
            upg_rst_q    <= 1'b1;
            prog_mode_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            deb_cnt_q    <= deb_cnt_d;
            rel_cnt_q    <= rel_cnt_d;
            armed_q      <= armed_d;
            load_count_q <= load_count_d;
            cpu_rst_q    <= cpu_rst_d;
            upg_rst_q    <= upg_rst_d;
            prog_mode_q  <= prog_mode_d;
        end
    end

    // Next-state logic: debounce in RUN, count writes in PROG, and time the
    // reset tail in RELEASE.
    always_comb begin
        state_d      = state_q;
        deb_cnt_d    = deb_cnt_q;
        rel_cnt_d    = rel_cnt_q;
        armed_d      = armed_q;
        load_count_d = load_count_q;

        case (state_q)
            ST_RUN: begin
                if (!start_pg) begin
                    // A low sample breaks the run and re-arms the button.
                    deb_cnt_d = '0;
                    armed_d   = 1'b1;
                end else if (armed_q && (deb_cnt_q == DEB_MAX)) begin
                    state_d      = ST_PROG;
                    deb_cnt_d    = '0;
                    load_count_d = '0;
                end else if (deb_cnt_q != DEB_MAX) begin
                    // Saturate while disarmed so a held button cannot wrap.
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end

            ST_PROG: begin
                // A write in the done cycle still counts.
                if (bus.upg_wen_o && (load_count_q != 16'hFFFF)) begin
                    load_count_d = load_count_q + 16'd1;
                end
                if (bus.upg_done_o) begin
                    state_d   = ST_RELEASE;
                    rel_cnt_d = '0;
                end
            end

            ST_RELEASE: begin
                if (rel_cnt_q == REL_MAX) begin
                    state_d   = ST_RUN;
                    rel_cnt_d = '0;
                    deb_cnt_d = '0;
                    // A button still held from the last session must be
                    // released before it can start another one.
                    armed_d   = ~start_pg;
                end else begin
                    rel_cnt_d = rel_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d   = ST_RELEASE;
                rel_cnt_d = '0;
            end
        endcase
    end

    // Registered mode outputs, decoded from the state being entered.
    always_comb begin
        cpu_rst_d   = 1'b1;
        upg_rst_d   = 1'b1;
        prog_mode_d = 1'b0;
        case (state_d)
            ST_RUN: begin
                cpu_rst_d   = 1'b0;
                upg_rst_d   = 1'b1;
                prog_mode_d = 1'b0;
            end
            ST_PROG: begin
                cpu_rst_d   = 1'b1;
                upg_rst_d   = 1'b0;
                prog_mode_d = 1'b1;
            end
            default: begin
                cpu_rst_d   = 1'b1;
                upg_rst_d   = 1'b1;
                prog_mode_d = 1'b0;
            end
        endcase
    end

    // Memory mux. It is keyed on the registered prog_mode, so an async rst
    // takes the UART off the memories at once.
    always_comb begin
        bus.imem_addr  = bus.cpu_imem_addr;
        bus.imem_wen   = 1'b0;
        bus.imem_wdata = 32'd0;
        bus.dmem_addr  = bus.cpu_dmem_addr;
        bus.dmem_wen   = bus.cpu_dmem_wen;
        bus.dmem_wdata = bus.cpu_dmem_wdata;

        if (prog_mode_q) begin
            bus.imem_addr  = ADDR_W'(bus.upg_adr_o[13:0]);
            bus.imem_wdata = bus.upg_dat_o;
            bus.imem_wen   = bus.upg_wen_o & ~bus.upg_adr_o[14];
            bus.dmem_addr  = ADDR_W'(bus.upg_adr_o[13:0]);
            bus.dmem_wdata = bus.upg_dat_o;
            bus.dmem_wen   = bus.upg_wen_o & bus.upg_adr_o[14];
        end else if (state_q == ST_RELEASE) begin
            // The CPU is still in reset, so any write it shows is junk.
            bus.dmem_wen = 1'b0;
        end
    end

    assign cpu_rst    = cpu_rst_q;
    assign upg_rst    = upg_rst_q;
    assign prog_mode  = prog_mode_q;
    assign load_count = load_count_q;
    assign state_o    = state_q;

endmodule
